// File: rtl/conv_output_sequencer_pkg.sv
// Shared definitions for the convolution output sequencer: traversal order
// encodings and helpers that size coordinates and derive output dimensions.
package conv_output_sequencer_pkg;

    typedef enum logic {
        ORDER_CH_FIRST = 1'b0,
        ORDER_X_FIRST  = 1'b1
    } order_e;

    // Coordinate width for an index range of n values, never narrower than one bit.
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Output extent along one axis: ceil(n / stride) with stride 1 or 2.
    function automatic int out_dim(input int n, input logic stride2);
        return stride2 ? (n + 1) / 2 : n;
    endfunction

endpackage

// File: rtl/conv_output_sequencer_wrap_counter.sv
// Up-counter that returns to zero after reaching a run-time limit; wrap flags
// the terminal count so callers can chain counters without a combinational loop.
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         arst_n_in,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == limit);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_output_sequencer.sv
// Tags each accumulator result with its (x, y, ch) output coordinate and hands it
// downstream through a single skid-free output register, one result per cycle.
module conv_output_sequencer
    import conv_output_sequencer_pkg::*;
#(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int OUTPUT_NB_CHANNELS = 32
) (
    input  logic                                          clk,
    input  logic                                          arst_n_in,
    input  logic                                          start,
    input  logic                                          cfg_stride2,
    input  logic                                          cfg_order,
    output logic                                          running,
    output logic                                          done,
    input  logic                                          acc_valid,
    output logic                                          acc_ready,
    input  logic [ACCUMULATION_WIDTH-1:0]                 acc_data,
    output logic                                          output_valid,
    input  logic                                          output_ready,
    output logic [ACCUMULATION_WIDTH-1:0]                 output_data,
    output logic [coord_width(FEATURE_MAP_WIDTH)-1:0]     output_x,
    output logic [coord_width(FEATURE_MAP_HEIGHT)-1:0]    output_y,
    output logic [coord_width(OUTPUT_NB_CHANNELS)-1:0]    output_ch,
    output logic                                          output_last
);

    localparam int XW = coord_width(FEATURE_MAP_WIDTH);
    localparam int YW = coord_width(FEATURE_MAP_HEIGHT);
    localparam int CW = coord_width(OUTPUT_NB_CHANNELS);

    localparam logic [XW-1:0] X_LIM_S1 = XW'(out_dim(FEATURE_MAP_WIDTH, 1'b0) - 1);
    localparam logic [XW-1:0] X_LIM_S2 = XW'(out_dim(FEATURE_MAP_WIDTH, 1'b1) - 1);
    localparam logic [YW-1:0] Y_LIM_S1 = YW'(out_dim(FEATURE_MAP_HEIGHT, 1'b0) - 1);
    localparam logic [YW-1:0] Y_LIM_S2 = YW'(out_dim(FEATURE_MAP_HEIGHT, 1'b1) - 1);
    localparam logic [CW-1:0] CH_LIM   = CW'(OUTPUT_NB_CHANNELS - 1);

    logic                          running_reg;
    logic                          done_reg;
    logic                          stride2_reg;
    order_e                        order_reg;
    logic                          output_valid_reg;
    logic                          output_last_reg;
    logic [ACCUMULATION_WIDTH-1:0] output_data_reg;
    logic [XW-1:0]                 output_x_reg;
    logic [YW-1:0]                 output_y_reg;
    logic [CW-1:0]                 output_ch_reg;

    logic          start_accept;
    logic          acc_fire;
    logic          layer_end;
    logic          x_en, y_en, ch_en;
    logic          x_wrap, y_wrap, ch_wrap;
    logic [XW-1:0] x_count, x_limit;
    logic [YW-1:0] y_count, y_limit;
    logic [CW-1:0] ch_count;

    assign start_accept = start && !running_reg;
    assign acc_ready    = running_reg && (!output_valid_reg || output_ready);
    assign acc_fire     = acc_valid && acc_ready;
    assign x_limit      = stride2_reg ? X_LIM_S2 : X_LIM_S1;
    assign y_limit      = stride2_reg ? Y_LIM_S2 : Y_LIM_S1;

    // Every counter sits at its limit only on the final beat, whatever the order,
    // and the chained wraps return all three to zero on that same beat.
    assign layer_end = acc_fire && x_wrap && y_wrap && ch_wrap;

    always_comb begin
        x_en  = 1'b0;
        y_en  = 1'b0;
        ch_en = 1'b0;
        if (order_reg == ORDER_X_FIRST) begin
            x_en  = acc_fire;
            y_en  = acc_fire && x_wrap;
            ch_en = acc_fire && x_wrap && y_wrap;
        end else begin
            ch_en = acc_fire;
            x_en  = acc_fire && ch_wrap;
            y_en  = acc_fire && ch_wrap && x_wrap;
        end
    end

    wrap_counter #(.W(XW)) u_x_counter (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .enable    (x_en),
        .clear     (start_accept),
        .limit     (x_limit),
        .count     (x_count),
        .wrap      (x_wrap)
    );

    wrap_counter #(.W(YW)) u_y_counter (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .enable    (y_en),
        .clear     (start_accept),
        .limit     (y_limit),
        .count     (y_count),
        .wrap      (y_wrap)
    );

    wrap_counter #(.W(CW)) u_ch_counter (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .enable    (ch_en),
        .clear     (start_accept),
        .limit     (CH_LIM),
        .count     (ch_count),
        .wrap      (ch_wrap)
    );

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            running_reg      <= 1'b0;
            done_reg         <= 1'b0;
            stride2_reg      <= 1'b0;
            order_reg        <= ORDER_CH_FIRST;
            output_valid_reg <= 1'b0;
            output_last_reg  <= 1'b0;
            output_data_reg  <= '0;
            output_x_reg     <= '0;
            output_y_reg     <= '0;
            output_ch_reg    <= '0;
        end else begin
            done_reg <= output_valid_reg && output_ready && output_last_reg;

            if (start_accept) begin
                running_reg <= 1'b1;
                stride2_reg <= cfg_stride2;
                order_reg   <= order_e'(cfg_order);
            end else if (layer_end) begin
                running_reg <= 1'b0;
            end

            // A load while the consumer drains the old word keeps the stream gap-free.
            if (acc_fire) begin
                output_valid_reg <= 1'b1;
                output_last_reg  <= layer_end;
                output_data_reg  <= acc_data;
                output_x_reg     <= x_count;
                output_y_reg     <= y_count;
                output_ch_reg    <= ch_count;
            end else if (output_ready) begin
                output_valid_reg <= 1'b0;
                output_last_reg  <= 1'b0;
            end
        end
    end

    assign running      = running_reg;
    assign done         = done_reg;
    assign output_valid = output_valid_reg;
    assign output_last  = output_last_reg;
    assign output_data  = output_data_reg;
    assign output_x     = output_x_reg;
    assign output_y     = output_y_reg;
    assign output_ch    = output_ch_reg;

endmodule

// File: tb/tb_conv_output_sequencer.sv
// Scoreboard bench for conv_output_sequencer on a 4x3 map with 2 channels:
// expected tags are queued at each accepted result and compared at hand-off.
module tb_conv_output_sequencer;

    localparam int AW = 32;
    localparam int FW = 4;
    localparam int FH = 3;
    localparam int NC = 2;

    typedef struct {
        int x;
        int y;
        int ch;
    } coord_t;

    typedef struct {
        logic [31:0] data;
        int          x;
        int          y;
        int          ch;
        logic        last;
    } exp_t;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic          cfg_stride2;
    logic          cfg_order;
    logic          running;
    logic          done;
    logic          acc_valid;
    logic          acc_ready;
    logic [AW-1:0] acc_data;
    logic          output_valid;
    logic          output_ready;
    logic [AW-1:0] output_data;
    logic [1:0]    output_x;
    logic [1:0]    output_y;
    logic [0:0]    output_ch;
    logic          output_last;

    coord_t coord_q[$];
    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     done_cnt = 0;
    logic   done_due = 1'b0;
    logic   acc_hs   = 1'b0;

    always #5 clk = ~clk;

    conv_output_sequencer #(
        .ACCUMULATION_WIDTH (AW),
        .FEATURE_MAP_WIDTH  (FW),
        .FEATURE_MAP_HEIGHT (FH),
        .OUTPUT_NB_CHANNELS (NC)
    ) dut (
        .clk          (clk),
        .arst_n_in    (arst_n_in),
        .start        (start),
        .cfg_stride2  (cfg_stride2),
        .cfg_order    (cfg_order),
        .running      (running),
        .done         (done),
        .acc_valid    (acc_valid),
        .acc_ready    (acc_ready),
        .acc_data     (acc_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_x     (output_x),
        .output_y     (output_y),
        .output_ch    (output_ch),
        .output_last  (output_last)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Runs at the falling edge, when DUT outputs and bench inputs are both settled.
    task automatic observe();
        exp_t   e;
        coord_t c;
        acc_hs = 1'b0;
        if (!arst_n_in) return;
        if (done || done_due) check_eq("done_pulse", done, done_due);
        if (done) done_cnt++;
        done_due = 1'b0;
        if (output_valid && output_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", output_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", output_data, e.data);
                check_eq("out_x", output_x, e.x);
                check_eq("out_y", output_y, e.y);
                check_eq("out_ch", output_ch, e.ch);
                check_eq("out_last", output_last, e.last);
                $display("out x=%0d y=%0d ch=%0d last=%0b data=%08h", output_x, output_y, output_ch, output_last, output_data);
                done_due = e.last;
            end
        end
        acc_hs = acc_valid && acc_ready;
        if (acc_hs) begin
            if (coord_q.size() == 0) begin
                check_eq("extra_accept", acc_ready, 1'b0);
            end else begin
                c      = coord_q.pop_front();
                e.data = acc_data;
                e.x    = c.x;
                e.y    = c.y;
                e.ch   = c.ch;
                e.last = (coord_q.size() == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic stall();
        logic [31:0] d;
        logic [1:0]  x, y;
        logic [0:0]  c;
        output_ready = 1'b0;
        d = output_data;
        x = output_x;
        y = output_y;
        c = output_ch;
        check_eq("stall_valid", output_valid, 1'b1);
        repeat (5) begin
            tick();
            check_eq("stall_acc_ready", acc_ready, 1'b0);
            check_eq("stall_valid_hold", output_valid, 1'b1);
            check_eq("stall_data", output_data, d);
            check_eq("stall_x", output_x, x);
            check_eq("stall_y", output_y, y);
            check_eq("stall_ch", output_ch, c);
        end
        output_ready = 1'b1;
    endtask

    task automatic run_layer(input logic s2, input logic ord, input int stall_at,
                             input logic restart, input int abort_at, input logic chain,
                             input logic tput);
        int ow, oh, n, sent, iters, d0;
        ow = s2 ? (FW + 1) / 2 : FW;
        oh = s2 ? (FH + 1) / 2 : FH;
        if (ord == 1'b0) begin
            for (int yi = 0; yi < oh; yi++)
                for (int xi = 0; xi < ow; xi++)
                    for (int ci = 0; ci < NC; ci++)
                        coord_q.push_back('{xi, yi, ci});
        end else begin
            for (int ci = 0; ci < NC; ci++)
                for (int yi = 0; yi < oh; yi++)
                    for (int xi = 0; xi < ow; xi++)
                        coord_q.push_back('{xi, yi, ci});
        end
        n = coord_q.size();
        $display("layer stride2=%0b order=%0b beats=%0d", s2, ord, n);

        cfg_stride2 = s2;
        cfg_order   = ord;
        start       = 1'b1;
        tick();
        start = 1'b0;
        d0 = done_cnt;
        check_eq("running_after_start", running, 1'b1);
        if (restart) begin
            cfg_stride2 = ~s2;
            cfg_order   = ~ord;
            start       = 1'b1;
            tick();
            start = 1'b0;
            check_eq("running_hold", running, 1'b1);
        end

        sent      = 0;
        iters     = 0;
        acc_valid = 1'b1;
        acc_data  = $urandom;
        while (sent < n && iters < 400) begin
            tick();
            iters++;
            if (acc_hs) begin
                sent++;
                acc_data = $urandom;
                if (sent == abort_at) begin
                    arst_n_in = 1'b0;
                    #1;
                    check_eq("abort_running", running, 1'b0);
                    check_eq("abort_valid", output_valid, 1'b0);
                    check_eq("abort_last", output_last, 1'b0);
                    check_eq("abort_data", output_data, 32'h0);
                    check_eq("abort_x", output_x, 0);
                    check_eq("abort_y", output_y, 0);
                    check_eq("abort_ch", output_ch, 0);
                    acc_valid = 1'b0;
                    exp_q.delete();
                    coord_q.delete();
                    done_due = 1'b0;
                    tick();
                    arst_n_in = 1'b1;
                    tick();
                    return;
                end
                if (sent == stall_at) stall();
            end
        end
        acc_valid = 1'b0;
        check_eq("beats_accepted", sent, n);
        if (tput) check_eq("cycles_per_layer", iters, n);

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check_eq("drained", exp_q.size(), 0);
        if (chain) begin
            check_eq("done_before_chain", done, 1'b1);
        end else begin
            tick();
            tick();
            check_eq("done_count", done_cnt - d0, 1);
            check_eq("running_end", running, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n_in    = 1'b0;
        start        = 1'b0;
        cfg_stride2  = 1'b0;
        cfg_order    = 1'b0;
        acc_valid    = 1'b0;
        acc_data     = '0;
        output_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_running", running, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_valid", output_valid, 1'b0);
        check_eq("rst_last", output_last, 1'b0);
        check_eq("rst_data", output_data, 32'h0);
        check_eq("rst_x", output_x, 0);
        check_eq("rst_y", output_y, 0);
        check_eq("rst_ch", output_ch, 0);
        check_eq("rst_acc_ready", acc_ready, 1'b0);
        arst_n_in = 1'b1;
        tick();

        // Results offered while idle must be refused.
        acc_valid = 1'b1;
        acc_data  = 32'hDEAD_BEEF;
        repeat (3) begin
            tick();
            check_eq("idle_acc_ready", acc_ready, 1'b0);
            check_eq("idle_valid", output_valid, 1'b0);
            check_eq("idle_running", running, 1'b0);
        end
        acc_valid = 1'b0;

        run_layer(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
        run_layer(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
        run_layer(1'b0, 1'b0, 7, 1'b0, 0, 1'b0, 1'b0);
        run_layer(1'b0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b0);
        run_layer(1'b0, 1'b0, 0, 1'b0, 10, 1'b0, 1'b0);
        run_layer(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        run_layer(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
        run_layer(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
